spi_target: RTL and testbench

- SPI responder (slave) for the SoC's SPI master peripheral: an external master drives CEN/SCLK/MOSI, and this block returns MISO.
- Synchronizes the SPI pins into clk and deserializes MSB-first bytes into an RX FIFO. Serializes a CPU-loaded TX byte back to the master.
- Sits on the CPU valid/ready bus as an IO peripheral with a 2-word register map (CTRL/STATUS and DATA), selected by address bit 2.

---
 rtl/spi_target_pkg.sv | 29 ++
 rtl/spi_target_fifo.sv | 57 +++++
 rtl/spi_target.sv | 232 +++++++++++++++++++++++
 tb/tb_spi_target.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI target: FSM states, bus addresses,
// STATUS bit positions and the TX byte selection helper.
package spi_target_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [31:0] KIANV_SPI_TARGET_CTRL = 32'h1000_0060;
  localparam logic [31:0] KIANV_SPI_TARGET_DATA = 32'h1000_0064;

  localparam int STAT_RX_AVAIL    = 0;
  localparam int STAT_TX_EMPTY    = 1;
  localparam int STAT_OVERRUN     = 2;
  localparam int STAT_CEN_ACTIVE  = 3;
  localparam int STAT_RX_IE       = 4;
  localparam int STAT_CS_IE       = 5;
  localparam int STAT_CS_EVT      = 6;
  localparam int STAT_RX_COUNT_LSB = 8;

  // A pending CPU byte takes priority over the fill pattern.
  function automatic logic [7:0] next_tx_byte(input logic hold_full,
                                              input logic [7:0] hold,
                                              input logic [7:0] fill);
    return hold_full ? hold : fill;
  endfunction

endpackage

// File: rtl/spi_target_fifo.sv
// Synchronous RX FIFO; a push into a full FIFO is accepted only when a pop
// happens in the same cycle.
module spi_target_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == {CW{1'b0}});
  assign do_push_s = push & (~full | pop);
  assign do_pop_s  = pop & ~empty;
  assign dout      = mem_r[rd_ptr_r];

  // Storage array
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count    <= {CW{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_target.sv
// SPI responder with CPU register interface (CTRL/STATUS, DATA).
// Optional interrupt output enabled by defining SPI_TARGET_IRQ_EN.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int         CPOL        = 1,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] FILL_BYTE   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid,
  output logic        ready,
  input  logic        ctrl,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
`ifdef SPI_TARGET_IRQ_EN
  output logic        irq,
`endif
  input  logic        spi_cen_i,
  input  logic        spi_sclk_i,
  input  logic        spi_mosi_i,
  output logic        spi_miso_o,
  output logic        spi_miso_oe
);

  localparam int   CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic CPOL_BIT = (CPOL != 0);

  logic [SYNC_STAGES-1:0] cen_sync_r, sclk_sync_r, mosi_sync_r;
  logic cen_d_r, sclk_d_r;
  logic cen_s, sclk_s, mosi_s;
  logic cen_fall_s, cen_rise_s, sclk_rise_s, sclk_fall_s;

  state_t     state_r;
  logic [2:0] bit_cnt_r;
  logic       wrapped_r;
  logic [7:0] rx_shift_r, tx_shift_r, tx_hold_r;
  logic       tx_empty_r, enable_r, overrun_r;
  logic [7:0] tx_next_s, rx_byte_s;

  logic acc_s, ctrl_wr_s, ctrl_rd_s, data_wr_s, data_rd_s;
  logic push_s, pop_s, ov_set_s;
  logic [7:0]    fifo_dout_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic [31:0]   status_s;
  logic          unused_s;

`ifdef SPI_TARGET_IRQ_EN
  logic rx_ie_r, cs_ie_r, cs_evt_r;
`endif

  assign cen_s       = cen_sync_r[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
  assign cen_fall_s  = cen_d_r & ~cen_s;
  assign cen_rise_s  = ~cen_d_r & cen_s;
  assign sclk_rise_s = ~sclk_d_r & sclk_s;
  assign sclk_fall_s = sclk_d_r & ~sclk_s;

  assign acc_s     = valid & ~ready;
  assign ctrl_wr_s = acc_s & ~ctrl & wstrb[0];
  assign ctrl_rd_s = acc_s & ~ctrl & ~(|wstrb);
  assign data_wr_s = acc_s & ctrl & wstrb[0];
  assign data_rd_s = acc_s & ctrl & ~(|wstrb);

  assign tx_next_s = next_tx_byte(~tx_empty_r, tx_hold_r, FILL_BYTE);
  assign rx_byte_s = {rx_shift_r[6:0], mosi_s};
  assign push_s    = (state_r == SHIFT) & ~cen_rise_s & sclk_rise_s & (bit_cnt_r == 3'd7);
  assign pop_s     = data_rd_s & ~fifo_empty_s;
  assign ov_set_s  = push_s & fifo_full_s & ~pop_s;
  assign unused_s  = ^{wdata[31:8], rx_shift_r[7]};

  spi_target_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .din   (rx_byte_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // CTRL/STATUS read image
  always_comb begin
    status_s                                = 32'h0000_0000;
    status_s[STAT_RX_AVAIL]                 = ~fifo_empty_s;
    status_s[STAT_TX_EMPTY]                 = tx_empty_r;
    status_s[STAT_OVERRUN]                  = overrun_r;
    status_s[STAT_CEN_ACTIVE]               = ~cen_d_r;
    status_s[STAT_RX_COUNT_LSB +: 8]        = 8'(fifo_count_s);
`ifdef SPI_TARGET_IRQ_EN
    status_s[STAT_RX_IE]                    = rx_ie_r;
    status_s[STAT_CS_IE]                    = cs_ie_r;
    status_s[STAT_CS_EVT]                   = cs_evt_r;
`else
    status_s[STAT_RX_IE]                    = 1'b0;
    status_s[STAT_CS_IE]                    = 1'b0;
    status_s[STAT_CS_EVT]                   = 1'b0;
`endif
  end

  // Pin synchronizers followed by one edge-detect stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cen_sync_r  <= {SYNC_STAGES{1'b1}};
      sclk_sync_r <= {SYNC_STAGES{CPOL_BIT}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      cen_d_r     <= 1'b1;
      sclk_d_r    <= CPOL_BIT;
    end else begin
      cen_sync_r  <= {cen_sync_r[SYNC_STAGES-2:0], spi_cen_i};
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk_i};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi_i};
      cen_d_r     <= cen_s;
      sclk_d_r    <= sclk_s;
    end
  end

  // Transfer FSM; wrapped_r marks a completed byte so the mode-3 leading
  // falling edge does not reload the TX byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      bit_cnt_r   <= 3'd0;
      wrapped_r   <= 1'b0;
      rx_shift_r  <= 8'h00;
      tx_shift_r  <= FILL_BYTE;
      tx_hold_r   <= 8'h00;
      tx_empty_r  <= 1'b1;
      spi_miso_o  <= FILL_BYTE[7];
      spi_miso_oe <= 1'b0;
    end else begin
      spi_miso_oe <= ~cen_s;
      case (state_r)
        IDLE: begin
          if (cen_fall_s && enable_r) begin
            tx_shift_r <= tx_next_s;
            spi_miso_o <= tx_next_s[7];
            tx_empty_r <= 1'b1;
            bit_cnt_r  <= 3'd0;
            wrapped_r  <= 1'b0;
            state_r    <= SHIFT;
          end else if (cen_fall_s || cen_rise_s) begin
            tx_shift_r <= FILL_BYTE;
            spi_miso_o <= FILL_BYTE[7];
          end else if (sclk_fall_s && !cen_s) begin
            tx_shift_r <= {tx_shift_r[6:0], tx_shift_r[7]};
            spi_miso_o <= tx_shift_r[6];
          end
        end
        SHIFT: begin
          if (cen_rise_s) begin
            state_r    <= IDLE;
            bit_cnt_r  <= 3'd0;
            wrapped_r  <= 1'b0;
            tx_shift_r <= FILL_BYTE;
            spi_miso_o <= FILL_BYTE[7];
          end else if (sclk_rise_s) begin
            rx_shift_r <= rx_byte_s;
            bit_cnt_r  <= bit_cnt_r + 3'd1;
            wrapped_r  <= (bit_cnt_r == 3'd7);
          end else if (sclk_fall_s) begin
            if (wrapped_r) begin
              tx_shift_r <= tx_next_s;
              spi_miso_o <= tx_next_s[7];
              tx_empty_r <= 1'b1;
              wrapped_r  <= 1'b0;
            end else if (bit_cnt_r != 3'd0) begin
              tx_shift_r <= {tx_shift_r[6:0], 1'b0};
              spi_miso_o <= tx_shift_r[6];
            end
          end
        end
        default: state_r <= IDLE;
      endcase
      if (data_wr_s) begin
        tx_hold_r  <= wdata[7:0];
        tx_empty_r <= 1'b0;
      end
    end
  end

  // Bus acknowledge, read data and control registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready     <= 1'b0;
      rdata     <= 32'h0000_0000;
      enable_r  <= 1'b0;
      overrun_r <= 1'b0;
`ifdef SPI_TARGET_IRQ_EN
      rx_ie_r   <= 1'b0;
      cs_ie_r   <= 1'b0;
      cs_evt_r  <= 1'b0;
      irq       <= 1'b0;
`endif
    end else begin
      ready <= acc_s;
      if (ctrl_rd_s) begin
        rdata <= status_s;
      end else if (data_rd_s) begin
        rdata <= fifo_empty_s ? 32'hFFFF_FFFF : {24'h00_0000, fifo_dout_s};
      end else begin
        rdata <= 32'h0000_0000;
      end
      if (ctrl_wr_s) enable_r <= wdata[0];
      if (ov_set_s) begin
        overrun_r <= 1'b1;
      end else if (ctrl_wr_s && wdata[STAT_OVERRUN]) begin
        overrun_r <= 1'b0;
      end
`ifdef SPI_TARGET_IRQ_EN
      if (ctrl_wr_s) begin
        rx_ie_r <= wdata[STAT_RX_IE];
        cs_ie_r <= wdata[STAT_CS_IE];
      end
      if (cen_rise_s) begin
        cs_evt_r <= 1'b1;
      end else if (ctrl_wr_s && wdata[STAT_CS_EVT]) begin
        cs_evt_r <= 1'b0;
      end
      irq <= (~fifo_empty_s & rx_ie_r) | (cs_evt_r & cs_ie_r);
`endif
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: a CPOL=1 and a CPOL=0 instance are
// driven by a bit-level SPI master and checked against a byte-level model.
module tb_spi_target;
  import spi_target_pkg::*;

  localparam int         H    = 6;
  localparam logic [7:0] FILL = 8'hFF;
  localparam int         DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  valid, ready, ctrl, cen, sclk, mosi, miso, oe;
  logic [3:0]  wstrb [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spi_target #(.CPOL(1)) dut_m3 (
    .clk(clk), .rst_n(rst_n), .valid(valid[0]), .ready(ready[0]), .ctrl(ctrl[0]),
    .wstrb(wstrb[0]), .wdata(wdata[0]), .rdata(rdata[0]),
    .spi_cen_i(cen[0]), .spi_sclk_i(sclk[0]), .spi_mosi_i(mosi[0]),
    .spi_miso_o(miso[0]), .spi_miso_oe(oe[0])
  );

  spi_target #(.CPOL(0)) dut_m0 (
    .clk(clk), .rst_n(rst_n), .valid(valid[1]), .ready(ready[1]), .ctrl(ctrl[1]),
    .wstrb(wstrb[1]), .wdata(wdata[1]), .rdata(rdata[1]),
    .spi_cen_i(cen[1]), .spi_sclk_i(sclk[1]), .spi_mosi_i(mosi[1]),
    .spi_miso_o(miso[1]), .spi_miso_oe(oe[1])
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic [31:0] exp;
    bit          chk;
  } vec_t;

  vec_t vecs [9];

  // Byte-level reference model
  logic [7:0] m_rxq [$];
  bit         m_ov, m_en, m_txp;
  logic [7:0] m_txb;

  function automatic int cpol_of(input int u);
    return (u == 0) ? 1 : 0;
  endfunction

  function automatic logic [31:0] m_status();
    return {16'h0000, 8'(m_rxq.size()), 4'h0, 1'b0, m_ov, ~m_txp, (m_rxq.size() != 0)};
  endfunction

  task automatic check(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cpol=%0d): got %h, expected %h", name, cpol_of(u), act, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      valid[u] = 1'b0; ctrl[u] = 1'b0; wstrb[u] = 4'h0; wdata[u] = 32'h0;
      cen[u] = 1'b1; sclk[u] = 1'(cpol_of(u)); mosi[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    m_rxq.delete(); m_ov = 1'b0; m_en = 1'b0; m_txp = 1'b0; m_txb = 8'h00;
  endtask

  task automatic bus(input int u, input logic [31:0] addr, input logic [3:0] strb,
                     input logic [31:0] d, output logic [31:0] rd);
    @(negedge clk);
    valid[u] = 1'b1; ctrl[u] = addr[2]; wstrb[u] = strb; wdata[u] = d;
    @(negedge clk);
    check("ready_one_cycle_after_valid", u, {31'h0, ready[u]}, 32'h1);
    rd = rdata[u];
    valid[u] = 1'b0; wstrb[u] = 4'h0;
    @(negedge clk);
    check("ready_single_pulse", u, {31'h0, ready[u]}, 32'h0);
  endtask

  task automatic rd_chk(input int u, input logic [31:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] v;
    bus(u, addr, 4'h0, 32'h0, v);
    check(name, u, v, exp);
  endtask

  task automatic wr(input int u, input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] d);
    logic [31:0] v;
    bus(u, addr, strb, d, v);
  endtask

  task automatic cs_low(input int u);
    cen[u] = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic cs_high(input int u);
    cen[u] = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  // Master: drives MOSI while SCLK is low, samples MISO just before the rise
  task automatic xfer(input int u, input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      sclk[u] = 1'b0;
      mosi[u] = tx[7-i];
      repeat (H) @(negedge clk);
      rx[7-i] = miso[u];
      sclk[u] = 1'b1;
      repeat (H) @(negedge clk);
    end
    if (cpol_of(u) == 0) begin
      sclk[u] = 1'b0;
      repeat (H) @(negedge clk);
    end
  endtask

  task automatic scenarios(input int u);
    logic [7:0] got;
    logic [31:0] v;
    // Register-level table
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      bus(u, vecs[i].addr, vecs[i].strb, vecs[i].wd, v);
      if (vecs[i].chk) check($sformatf("vec%0d", i), u, v, vecs[i].exp);
    end
    cs_low(u);
    xfer(u, 8'h00, 8, got);
    check("overwritten_tx_byte", u, {24'h0, got}, 32'h0000_005A);
    cs_high(u);

    // Basic loopback
    apply_reset();
    wr(u, KIANV_SPI_TARGET_DATA, 4'hF, 32'h0000_00A5);
    wr(u, KIANV_SPI_TARGET_CTRL, 4'h1, 32'h0000_0001);
    cs_low(u);
    rd_chk(u, KIANV_SPI_TARGET_CTRL, 32'h0000_000A, "status_in_frame");
    xfer(u, 8'h3C, 8, got);
    check("miso_byte_a5", u, {24'h0, got}, 32'h0000_00A5);
    cs_high(u);
    rd_chk(u, KIANV_SPI_TARGET_CTRL, 32'h0000_0103, "status_one_byte");
    rd_chk(u, KIANV_SPI_TARGET_DATA, 32'h0000_003C, "rx_byte_3c");
    rd_chk(u, KIANV_SPI_TARGET_DATA, 32'hFFFF_FFFF, "empty_read");
    rd_chk(u, KIANV_SPI_TARGET_CTRL, 32'h0000_0002, "status_drained");

    // Overrun with a full FIFO
    wr(u, KIANV_SPI_TARGET_CTRL, 4'h1, 32'h0000_0001);
    cs_low(u);
    for (int i = 1; i <= 5; i++) begin
      xfer(u, 8'(i), 8, got);
      check("fill_byte_no_tx", u, {24'h0, got}, {24'h0, FILL});
    end
    cs_high(u);
    rd_chk(u, KIANV_SPI_TARGET_CTRL, 32'h0000_0407, "status_overrun");
    for (int i = 1; i <= 4; i++) rd_chk(u, KIANV_SPI_TARGET_DATA, 32'(i), "fifo_order");
    wr(u, KIANV_SPI_TARGET_CTRL, 4'h1, 32'h0000_0005);
    rd_chk(u, KIANV_SPI_TARGET_CTRL, 32'h0000_0002, "overrun_cleared");

    // Aborted partial byte is discarded
    cs_low(u);
    xfer(u, 8'hF0, 5, got);
    cs_high(u);
    cs_low(u);
    xfer(u, 8'h81, 8, got);
    cs_high(u);
    rd_chk(u, KIANV_SPI_TARGET_CTRL, 32'h0000_0103, "status_after_abort");
    rd_chk(u, KIANV_SPI_TARGET_DATA, 32'h0000_0081, "rx_after_abort");

    // Two fill bytes, then reset in the middle of a byte
    cs_low(u);
    xfer(u, 8'h11, 8, got);
    check("two_byte_first_fill", u, {24'h0, got}, {24'h0, FILL});
    xfer(u, 8'h22, 8, got);
    check("two_byte_second_fill", u, {24'h0, got}, {24'h0, FILL});
    cs_high(u);
    rd_chk(u, KIANV_SPI_TARGET_DATA, 32'h0000_0011, "two_byte_rx0");
    rd_chk(u, KIANV_SPI_TARGET_DATA, 32'h0000_0022, "two_byte_rx1");
    cs_low(u);
    xfer(u, 8'h55, 3, got);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", u, {31'h0, ready[u]}, 32'h0);
    check("rst_rdata", u, rdata[u], 32'h0);
    check("rst_miso", u, {31'h0, miso[u]}, {31'h0, FILL[7]});
    check("rst_miso_oe", u, {31'h0, oe[u]}, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    xfer(u, 8'h55, 5, got);
    cs_high(u);
    rd_chk(u, KIANV_SPI_TARGET_CTRL, 32'h0000_0002, "status_after_reset");
  endtask

  task automatic random_run(input int u, input int iters);
    logic [7:0]  got, b, exp_b;
    logic [31:0] d;
    int n;
    apply_reset();
    for (int it = 0; it < iters; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          d = $urandom;
          wr(u, KIANV_SPI_TARGET_DATA, ($urandom_range(0, 1) == 1) ? 4'hF : 4'h1, d);
          m_txp = 1'b1; m_txb = d[7:0];
        end
        1: begin
          if (m_rxq.size() != 0) rd_chk(u, KIANV_SPI_TARGET_DATA, {24'h0, m_rxq.pop_front()}, "rand_data");
          else rd_chk(u, KIANV_SPI_TARGET_DATA, 32'hFFFF_FFFF, "rand_data_empty");
        end
        2: rd_chk(u, KIANV_SPI_TARGET_CTRL, m_status(), "rand_status");
        3: begin
          d = {29'h0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 3) != 0)};
          wr(u, KIANV_SPI_TARGET_CTRL, 4'h1, d);
          m_en = d[0];
          if (d[2]) m_ov = 1'b0;
        end
        default: begin
          n = $urandom_range(1, 2);
          cs_low(u);
          for (int k = 0; k < n; k++) begin
            b = 8'($urandom);
            exp_b = (k == 0 && m_en && m_txp) ? m_txb : FILL;
            xfer(u, b, 8, got);
            check("rand_miso", u, {24'h0, got}, {24'h0, exp_b});
            if (m_en) begin
              if (m_rxq.size() == DEPTH) m_ov = 1'b1;
              else m_rxq.push_back(b);
            end
          end
          if (m_en) m_txp = 1'b0;
          cs_high(u);
        end
      endcase
    end
    rd_chk(u, KIANV_SPI_TARGET_CTRL, m_status(), "rand_final_status");
  endtask

  initial begin
    vecs[0] = '{KIANV_SPI_TARGET_CTRL, 4'h0, 32'h0,         32'h0000_0002, 1'b1};
    vecs[1] = '{KIANV_SPI_TARGET_DATA, 4'h0, 32'h0,         32'hFFFF_FFFF, 1'b1};
    vecs[2] = '{KIANV_SPI_TARGET_CTRL, 4'h0, 32'h0,         32'h0000_0002, 1'b1};
    vecs[3] = '{KIANV_SPI_TARGET_DATA, 4'hF, 32'h1234_56A5, 32'h0,         1'b0};
    vecs[4] = '{KIANV_SPI_TARGET_CTRL, 4'h0, 32'h0,         32'h0000_0000, 1'b1};
    vecs[5] = '{KIANV_SPI_TARGET_DATA, 4'h1, 32'h0000_005A, 32'h0,         1'b0};
    vecs[6] = '{KIANV_SPI_TARGET_CTRL, 4'h1, 32'h0000_0075, 32'h0,         1'b0};
    vecs[7] = '{KIANV_SPI_TARGET_CTRL, 4'h0, 32'h0,         32'h0000_0000, 1'b1};
    vecs[8] = '{KIANV_SPI_TARGET_DATA, 4'h0, 32'h0,         32'hFFFF_FFFF, 1'b1};

    apply_reset();
    for (int u = 0; u < 2; u++) begin
      check("reset_ready", u, {31'h0, ready[u]}, 32'h0);
      check("reset_rdata", u, rdata[u], 32'h0);
      check("reset_miso", u, {31'h0, miso[u]}, {31'h0, FILL[7]});
      check("reset_miso_oe", u, {31'h0, oe[u]}, 32'h0);
    end
    for (int u = 0; u < 2; u++) begin
      scenarios(u);
      random_run(u, 40);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #(800_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
